// File: rtl/adder_arbiter_if.sv
// Signal bundle between adder_arbiter, its requesters, the shared cl_adder and the response consumer.
// The master modport is the arbiter's view; slave is the surrounding datapath.
interface adder_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_A;
  logic [NREQ*WIDTH-1:0] req_B;
  logic [NREQ-1:0]       req_ready;

  logic [WIDTH-1:0]      add_A;
  logic [WIDTH-1:0]      add_B;
  logic                  add_Cin;
  logic [WIDTH-1:0]      add_out;
  logic                  add_overflow;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_overflow;

  modport master (
    input  req_valid, req_op, req_A, req_B, add_out, add_overflow, rsp_ready,
    output req_ready, add_A, add_B, add_Cin, rsp_valid, rsp_id, rsp_sum, rsp_overflow
  );

  modport slave (
    output req_valid, req_op, req_A, req_B, add_out, add_overflow, rsp_ready,
    input  req_ready, add_A, add_B, add_Cin, rsp_valid, rsp_id, rsp_sum, rsp_overflow
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one combinational adder among NREQ requesters,
// with a single registered response slot under valid/ready backpressure.
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  adder_arbiter_if.master bus
);

  logic [IDW-1:0]   r_ptr;
  logic             r_rspValid;
  logic [IDW-1:0]   r_rspId;
  logic [WIDTH-1:0] r_rspSum;
  logic             r_rspOverflow;

  logic             w_slotFree;
  logic             w_grantValid;
  logic [IDW-1:0]   w_grantIdx;
  logic [NREQ-1:0]  w_grant;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;
  logic             w_opSub;

  // Gating with reset_n keeps grants and adder drive quiet while reset is held.
  assign w_slotFree = reset_n && (!r_rspValid || bus.rsp_ready);

  // Scanning downward lets the last hit win, which is the first valid requester at or above r_ptr.
  always_comb begin
    int idx;
    idx          = 0;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    if (w_slotFree) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = (int'(r_ptr) + k) % NREQ;
        if (bus.req_valid[idx]) begin
          w_grantValid = 1'b1;
          w_grantIdx   = IDW'(idx);
        end
      end
    end
  end

  assign w_grant = w_grantValid ? (NREQ'(1) << w_grantIdx) : '0;

  always_comb begin
    w_opA   = '0;
    w_opB   = '0;
    w_opSub = 1'b0;
    if (w_grantValid) begin
      w_opA   = bus.req_A[int'(w_grantIdx) * WIDTH +: WIDTH];
      w_opB   = bus.req_B[int'(w_grantIdx) * WIDTH +: WIDTH];
      w_opSub = bus.req_op[w_grantIdx];
    end
  end

  // Subtraction is A + ~B + 1 through the same adder.
  assign bus.req_ready = w_grant;
  assign bus.add_A     = w_opA;
  assign bus.add_B     = w_opSub ? ~w_opB : w_opB;
  assign bus.add_Cin   = w_opSub;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr         <= '0;
      r_rspValid    <= 1'b0;
      r_rspId       <= '0;
      r_rspSum      <= '0;
      r_rspOverflow <= 1'b0;
    end else if (w_grantValid) begin
      r_rspValid    <= 1'b1;
      r_rspId       <= w_grantIdx;
      r_rspSum      <= bus.add_out;
      r_rspOverflow <= bus.add_overflow;
      r_ptr         <= (int'(w_grantIdx) == NREQ - 1) ? '0 : w_grantIdx + 1'b1;
    end else if (r_rspValid && bus.rsp_ready) begin
      r_rspValid    <= 1'b0;
    end
  end

  assign bus.rsp_valid    = r_rspValid;
  assign bus.rsp_id       = r_rspId;
  assign bus.rsp_sum      = r_rspSum;
  assign bus.rsp_overflow = r_rspOverflow;

endmodule
